// File: rtl/barreira_ctrl_if.sv
// Bundle between the plate-recognition front end / barrier actuator side and
// the barrier controller. The front end (master) drives the plate read and the
// vehicle sensor. The controller (slave) returns barrier status and bookkeeping.
interface barreira_ctrl_if #(
  parameter int PLATE_W = 24,
  parameter int CNT_W   = 7
);
  logic [PLATE_W-1:0] matricula;
  logic               matr_val;
  logic               sensor_carro;
  logic               barreira_aberta;
  logic [PLATE_W-1:0] matr_atual;
  logic [CNT_W-1:0]   ciclo_atual;
  logic [CNT_W-1:0]   ciclo_fecho;
  logic [CNT_W-1:0]   n_passagens;
  logic               fecho_pulso;

  modport master (
    output matricula, matr_val, sensor_carro,
    input  barreira_aberta, matr_atual, ciclo_atual, ciclo_fecho,
           n_passagens, fecho_pulso
  );

  modport slave (
    input  matricula, matr_val, sensor_carro,
    output barreira_aberta, matr_atual, ciclo_atual, ciclo_fecho,
           n_passagens, fecho_pulso
  );
endinterface

// File: rtl/barreira_ctrl.sv
// Parking-barrier controller. It accepts non-zero validated plate reads and
// holds the barrier open for OPEN_CYCLES cycles. Each new read restarts that
// window. After expiry the barrier stays open while a vehicle is still under
// the boom. A free-running cycle counter lets the controller publish the
// scheduled close cycle of the last accepted plate.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   FECHADA | barrier closed, waiting for a plate
//   ABERTA  | barrier open, hold timer counting down to zero
//   ESPERA  | hold time expired, vehicle still present, waiting for it
//
// OPEN_CYCLES must lie in 1 .. 2**CNT_W-1 so that the reload value fits the
// timer.
module barreira_ctrl #(
  parameter int OPEN_CYCLES = 6,
  parameter int CNT_W       = 7,
  parameter int PLATE_W     = 24
) (
  input logic            clk,
  input logic            rst_n,
  barreira_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    FECHADA = 2'd0,
    ABERTA  = 2'd1,
    ESPERA  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] OPEN_C = CNT_W'(OPEN_CYCLES);
  // The timer counts the cycles that remain after the accepting edge,
  // so it is reloaded with one less than the hold time.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] N_MAX  = {CNT_W{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   timer_nxt;
  logic               accept;
  logic               close_evt;

  logic               aberta_q;
  logic               pulso_q;
  logic [PLATE_W-1:0] plate_q;
  logic [CNT_W-1:0]   ciclo_q;
  logic [CNT_W-1:0]   fecho_q;
  logic [CNT_W-1:0]   npass_q;

  // A plate code of zero means "no plate", so it is never accepted.
  assign accept = bus.matr_val && (bus.matricula != '0);

  // Next-state and timer decode. An accept has priority over expiry and over
  // sensor release.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    close_evt = 1'b0;
    if (accept) begin
      state_nxt = ABERTA;
      timer_nxt = RELOAD;
    end else begin
      case (state)
        FECHADA: begin
          state_nxt = FECHADA;
        end
        ABERTA: begin
          if (timer != '0) begin
            timer_nxt = timer - 1'b1;
          end else if (!bus.sensor_carro) begin
            state_nxt = FECHADA;
            close_evt = 1'b1;
          end else begin
            state_nxt = ESPERA;
          end
        end
        ESPERA: begin
          if (!bus.sensor_carro) begin
            state_nxt = FECHADA;
            close_evt = 1'b1;
          end
        end
        default: begin
          state_nxt = FECHADA;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // State and hold-timer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FECHADA;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Barrier command and close pulse are registered from the next state.
  // A reset clears both, so a reset never produces a close pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aberta_q <= 1'b0;
      pulso_q  <= 1'b0;
    end else begin
      aberta_q <= (state_nxt != FECHADA);
      pulso_q  <= close_evt;
    end
  end

  // Free-running cycle counter. It wraps at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ciclo_q <= '0;
    end else begin
      ciclo_q <= ciclo_q + 1'b1;
    end
  end

  // Per-accept bookkeeping: last plate, scheduled close cycle (modulo
  // counter width), and a passage count that saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      plate_q <= '0;
      fecho_q <= '0;
      npass_q <= '0;
    end else if (accept) begin
      plate_q <= bus.matricula;
      fecho_q <= ciclo_q + OPEN_C;
      if (npass_q != N_MAX) begin
        npass_q <= npass_q + 1'b1;
      end
    end
  end

  assign bus.barreira_aberta = aberta_q;
  assign bus.fecho_pulso     = pulso_q;
  assign bus.matr_atual      = plate_q;
  assign bus.ciclo_atual     = ciclo_q;
  assign bus.ciclo_fecho     = fecho_q;
  assign bus.n_passagens     = npass_q;

endmodule

// File: tb/tb_barreira_ctrl.sv
// Testbench for barreira_ctrl. The first part is a table of hand-computed
// vectors. Hand-written sequences then cover extension, sensor hold,
// wrap/saturation, an invalid plate and reset while open. The last part is a
// randomized run checked against a deadline-based reference model.
module tb_barreira_ctrl;
  localparam int OPEN    = 6;
  localparam int CNT_W   = 7;
  localparam int PLATE_W = 24;

  logic clk = 1'b0;
  logic rst_n;

  barreira_ctrl_if #(.PLATE_W(PLATE_W), .CNT_W(CNT_W)) ifc ();

  barreira_ctrl #(.OPEN_CYCLES(OPEN), .CNT_W(CNT_W), .PLATE_W(PLATE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int hi_cnt   = 0;
  int pu_cnt   = 0;

  // Reference model. An accept at edge e arms a deadline at edge e+OPEN.
  // From that edge on, the first edge that sees the sensor low closes the
  // barrier.
  int                 edge_n = 0;
  int                 m_exp  = 0;
  logic               m_open, m_pulse;
  logic [PLATE_W-1:0] m_plate;
  logic [CNT_W-1:0]   m_fecho, m_np, m_cyc;

  task automatic model_step(input logic r, input logic v,
                            input logic [PLATE_W-1:0] p, input logic s);
    if (!r) begin
      m_open = 0; m_pulse = 0; m_plate = '0;
      m_fecho = '0; m_np = '0; m_cyc = '0;
    end else begin
      m_pulse = 0;
      if (v && p != 0) begin
        m_plate = p;
        m_fecho = 7'((int'(m_cyc) + OPEN) % 128);
        if (m_np < 127) m_np = m_np + 7'd1;
        m_open = 1;
        m_exp  = edge_n + OPEN;
      end else if (m_open && edge_n >= m_exp && !s) begin
        m_open  = 0;
        m_pulse = 1;
      end
      m_cyc = 7'((int'(m_cyc) + 1) % 128);
    end
    edge_n++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v,
                       input logic [PLATE_W-1:0] p, input logic s);
    rst_n = r; ifc.matr_val = v; ifc.matricula = p; ifc.sensor_carro = s;
    @(posedge clk); #1;
    model_step(r, v, p, s);
    if (ifc.barreira_aberta) hi_cnt++;
    if (ifc.fecho_pulso) pu_cnt++;
  endtask

  task automatic check_model();
    chk("aberta", 32'(ifc.barreira_aberta), 32'(m_open));
    chk("pulso",  32'(ifc.fecho_pulso),     32'(m_pulse));
    chk("plate",  32'(ifc.matr_atual),      32'(m_plate));
    chk("fecho",  32'(ifc.ciclo_fecho),     32'(m_fecho));
    chk("npass",  32'(ifc.n_passagens),     32'(m_np));
    chk("ciclo",  32'(ifc.ciclo_atual),     32'(m_cyc));
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [PLATE_W-1:0] p, input logic s);
    drive(r, v, p, s);
    check_model();
  endtask

  typedef struct {
    logic               r, v;
    logic [PLATE_W-1:0] p;
    logic               s;
    logic               e_open, e_pulse;
    logic [PLATE_W-1:0] e_plate;
    logic [CNT_W-1:0]   e_fecho, e_np, e_cyc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [PLATE_W-1:0] p, logic s,
                              logic eo, logic ep, logic [PLATE_W-1:0] epl,
                              logic [CNT_W-1:0] ef, logic [CNT_W-1:0] en,
                              logic [CNT_W-1:0] ec);
    vec_t t;
    t.r = r; t.v = v; t.p = p; t.s = s;
    t.e_open = eo; t.e_pulse = ep; t.e_plate = epl;
    t.e_fecho = ef; t.e_np = en; t.e_cyc = ec;
    return t;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CNT_W-1:0]   np_save;
    logic [PLATE_W-1:0] pl_save;
    logic               sens;
    rst_n = 1'b0; ifc.matr_val = 1'b0; ifc.matricula = '0; ifc.sensor_carro = 1'b0;

    // Reset rows, idle to cycle 10, then accept and observe a full open period.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 24'hABC123, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 7'(i)));
    tbl.push_back(mk(1, 1, 24'h123456, 0, 1, 0, 24'h123456, 16, 1, 11));
    for (int i = 12; i <= 16; i++)
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 24'h123456, 16, 1, 7'(i)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 24'h123456, 16, 1, 17));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 24'h123456, 16, 1, 18));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 24'h123456, 16, 1, 19));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].p, tbl[i].s);
      chk("tbl_aberta", 32'(ifc.barreira_aberta), 32'(tbl[i].e_open));
      chk("tbl_pulso",  32'(ifc.fecho_pulso),     32'(tbl[i].e_pulse));
      chk("tbl_plate",  32'(ifc.matr_atual),      32'(tbl[i].e_plate));
      chk("tbl_fecho",  32'(ifc.ciclo_fecho),     32'(tbl[i].e_fecho));
      chk("tbl_npass",  32'(ifc.n_passagens),     32'(tbl[i].e_np));
      chk("tbl_ciclo",  32'(ifc.ciclo_atual),     32'(tbl[i].e_cyc));
    end

    // Extension: a second accept 3 cycles into the open period gives 9 high cycles.
    step(0, 0, 0, 0);
    hi_cnt = 0; pu_cnt = 0;
    step(1, 1, 24'hA1B2C3, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 24'h00BEEF, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
    chk("ext_high",   32'(hi_cnt), 32'd9);
    chk("ext_pulses", 32'(pu_cnt), 32'd1);
    chk("ext_npass",  32'(ifc.n_passagens), 32'd2);
    chk("ext_plate",  32'(ifc.matr_atual), 32'h00BEEF);

    // Sensor hold: the vehicle stays 5 cycles past expiry, and the barrier
    // closes one cycle after the sensor falls.
    hi_cnt = 0; pu_cnt = 0;
    step(1, 1, 24'h0C0C0C, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    chk("esp_hold", 32'(ifc.barreira_aberta), 32'd1);
    chk("esp_nopulse", 32'(pu_cnt), 32'd0);
    step(1, 0, 0, 0);
    chk("esp_close", 32'(ifc.barreira_aberta), 32'd0);
    chk("esp_pulse", 32'(ifc.fecho_pulso), 32'd1);
    chk("esp_high",  32'(hi_cnt), 32'd11);

    // An accept while in ESPERA reloads the full hold time.
    step(1, 1, 24'h0D0D0D, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    hi_cnt = 0; pu_cnt = 0;
    step(1, 1, 24'h0E0E0E, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("esp_reload_high", 32'(hi_cnt), 32'd6);
    chk("esp_reload_pulse", 32'(pu_cnt), 32'd1);

    // Wrap: an accept at ciclo_atual=125 gives ciclo_fecho=3.
    step(0, 0, 0, 0);
    for (int i = 0; i < 125; i++) step(1, 0, 0, 0);
    chk("wrap_pre", 32'(ifc.ciclo_atual), 32'd125);
    step(1, 1, 24'h777777, 0);
    chk("wrap_fecho", 32'(ifc.ciclo_fecho), 32'd3);

    // Saturation after 130 more accepts.
    for (int i = 0; i < 130; i++) step(1, 1, 24'(i + 1), 0);
    chk("sat_npass", 32'(ifc.n_passagens), 32'd127);

    // Plate 0 with a valid strobe while closed leaves everything unchanged.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    np_save = ifc.n_passagens; pl_save = ifc.matr_atual;
    step(1, 1, 0, 0);
    chk("inv_aberta", 32'(ifc.barreira_aberta), 32'd0);
    chk("inv_npass",  32'(ifc.n_passagens), 32'(np_save));
    chk("inv_plate",  32'(ifc.matr_atual), 32'(pl_save));

    // Reset while open: the barrier drops without a close pulse.
    step(1, 1, 24'h999999, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_aberta", 32'(ifc.barreira_aberta), 32'd0);
    chk("rst_pulso",  32'(ifc.fecho_pulso), 32'd0);
    step(1, 0, 0, 0);
    chk("rst_pulso2", 32'(ifc.fecho_pulso), 32'd0);

    // Randomized run against the model.
    sens = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r, v;
      logic [PLATE_W-1:0] p;
      r = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 9) < 2);
      p = ($urandom_range(0, 4) == 0) ? '0 : PLATE_W'($urandom);
      if ($urandom_range(0, 5) == 0) sens = ~sens;
      step(r, v, p, sens);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
